nn_layer_sequencer: RTL and testbench
=====================================

Name: nn_layer_sequencer

Overview:
- Central scheduler for the NN inference pipeline: ConV1, MP1, ConV2, ConV3, MP2, FC1, FC2, FC3.
- Replaces direct end-to-start daisy-chaining between layers. Issues one start pulse per layer in order and waits for that layer's end pulse.
- Drives the grant/select that tells the memory-port MUX which layer owns the shared RAM/ROM ports.
- Adds a per-layer watchdog, abort, an error report and a total-cycle counter for PS readback.

Parameters:
- NUM_LAYERS, 8: number of sequenced layers; index 0 = ConV1 … 7 = FC3.
- TIMEOUT_CYC, 4000000: maximum cycles a layer may stay in WAIT before error.
- WD_W, 23: watchdog counter width; must satisfy 2^WD_W > TIMEOUT_CYC.
- CNT_W, 32: width of the total run-cycle counter.

Ports:
- sys_clk, input, 1: single system clock; all logic on its rising edge.
- rst, input, 1: asynchronous, active-high reset.
- start_flag, input, 1: run request from PS; only its rising edge is used.
- abort, input, 1: synchronous abort, level-sensitive.
- end_in, input, NUM_LAYERS: per-layer one-cycle completion pulses.
- start_out, output, NUM_LAYERS: per-layer one-cycle start pulses.
- grant, output, NUM_LAYERS: one-hot memory ownership to the MUX; all-zero = no owner.
- layer_sel, output, 4: binary index of the granted layer; 4'hF when none.
- busy, output, 1: high in LAUNCH, WAIT and GAP.
- end_flag, output, 1: run-complete level; cleared by the next accepted start or by abort.
- error, output, 1: sticky error level.
- err_layer, output, 4: index of the layer that caused the error; 4'hF when no error.
- err_code, output, 2: 0 = none, 1 = timeout, 2 = spurious end.
- cycle_count, output, CNT_W: cycles spent in the last or current run.

Behaviour:
- Reset values: start_out=0, grant=0, layer_sel=4'hF, busy=0, end_flag=0, error=0, err_layer=4'hF, err_code=0, cycle_count=0. State=IDLE, idx=0.
- Start edge detect: a registered copy of start_flag. start_edge = start_flag & ~start_q.
- States: IDLE, LAUNCH, WAIT, GAP, DONE, ERROR.
- IDLE:
  - start_edge → LAUNCH with idx=0.
  - On that transition: cycle_count cleared, end_flag cleared.
- LAUNCH (exactly 1 cycle):
  - start_out[idx]=1, grant[idx]=1, layer_sel=idx.
  - Watchdog cleared.
  - → WAIT.
- WAIT:
  - grant[idx] held; the watchdog increments each cycle.
  - end_in[idx]=1 and idx==NUM_LAYERS-1 → DONE.
  - end_in[idx]=1 otherwise → GAP.
  - end_in[j]=1 with j≠idx → ERROR, err_code=2, err_layer=j. If several j are set, the lowest j is reported.
  - Watchdog reaches TIMEOUT_CYC → ERROR, err_code=1, err_layer=idx.
  - Priority within WAIT: correct end_in[idx] > spurious end > timeout.
- GAP (exactly 1 cycle):
  - grant=0, layer_sel=4'hF; this is the bus turnaround.
  - idx←idx+1 → LAUNCH.
- Latency: end_in[k] at cycle t → start_out[k+1] at t+2. Start edge at t → start_out[0] at t+1.
- DONE:
  - end_flag=1, busy=0, grant=0.
  - start_edge → LAUNCH with idx=0, clearing end_flag and cycle_count.
- ERROR:
  - error=1, busy=0, grant=0; err fields held.
  - start_flag is ignored. Only abort or rst leaves ERROR.
- abort, in any state: next state IDLE.
  - Clears start_out, grant, busy, end_flag, error and the err fields.
  - cycle_count is retained.
  - abort beats every other event in the same cycle.
- start_edge while busy or in ERROR: ignored, not queued.
- end_in while in IDLE, DONE or GAP: ignored, no error.
- cycle_count: increments in LAUNCH, WAIT and GAP; frozen in all other states; saturates at 2^CNT_W-1.
- All outputs are registered; nothing is combinational from inputs to outputs.
- Asynchronous rst during a run: all outputs go to reset values immediately. The next run requires a new start_flag edge; if start_flag is already high, it must fall and rise again.

Decomposition:
- Package nn_seq_pkg holds:
  - the state enum;
  - layer index constants L_CONV1=0 … L_FC3=7;
  - SEL_NONE=4'hF;
  - ERR_NONE / ERR_TIMEOUT / ERR_SPURIOUS codes.
- One sub-module, nn_seq_watchdog:
  - ports clr, en, expired; parameters TIMEOUT_CYC, WD_W.
  - Saturating counter; expired is a registered compare.

Test Plan:
- Nominal run, 8 responder models each pulsing end 10 cycles after their start:
  - start_out pulses in index order 0..7, each 2 cycles after the previous end.
  - grant is one-hot and never overlaps between layers.
  - end_flag rises 1 cycle after end_in[7]; cycle_count = 8×12 = 96 ±1 per boundary, exact value checked against a model.
- Timeout, TIMEOUT_CYC=50 with layer 3 never ending:
  - error=1, err_code=1, err_layer=3 at 50 cycles after WAIT entry; grant=0.
  - start_flag edges are then ignored.
  - abort returns the block to IDLE with error cleared.
- Spurious end: end_in[5] pulsed while layer 2 is granted → ERROR, err_code=2, err_layer=5.
- Simultaneous events:
  - abort and end_in[idx] in the same cycle → IDLE; the next layer is not started.
  - end_in[idx] on the cycle the watchdog expires → GAP; no error.
- Restart and level start:
  - start_flag held high through DONE gives no second run.
  - A low-then-high start_flag starts a new run with end_flag cleared and cycle_count reset.
- Reset mid-run: rst asserted in WAIT of layer 4 → all outputs take reset values asynchronously, before the next sys_clk edge.

Source files
------------

// File: rtl/nn_seq_pkg.sv
// Shared types and constants for the NN layer sequencer.
//   state_t         : sequencer FSM states
//   L_*             : layer index of each pipeline stage
//   SEL_NONE        : layer_sel / err_layer value meaning "no layer"
//   ERR_*           : err_code encodings
package nn_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_WAIT   = 3'd2,
        S_GAP    = 3'd3,
        S_DONE   = 3'd4,
        S_ERROR  = 3'd5
    } state_t;

    localparam int unsigned L_CONV1 = 0;
    localparam int unsigned L_MP1   = 1;
    localparam int unsigned L_CONV2 = 2;
    localparam int unsigned L_CONV3 = 3;
    localparam int unsigned L_MP2   = 4;
    localparam int unsigned L_FC1   = 5;
    localparam int unsigned L_FC2   = 6;
    localparam int unsigned L_FC3   = 7;

    localparam logic [3:0] SEL_NONE = 4'hF;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd1;
    localparam logic [1:0] ERR_SPURIOUS = 2'd2;

endpackage

// File: rtl/nn_seq_watchdog.sv
// Per-layer watchdog: saturating cycle counter with a registered expiry flag.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : restart the count (held at zero this cycle)
//   en       : count one cycle
//   expired  : registered; high from the cycle in which the owner has spent
//              TIMEOUT_CYC enabled cycles, so the owner can act on that cycle
module nn_seq_watchdog #(
    parameter int unsigned TIMEOUT_CYC = 4000000,
    parameter int unsigned WD_W        = 23
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    // Flag one count early: the registered flag then lines up with the
    // TIMEOUT_CYC-th enabled cycle rather than the one after it.
    localparam logic [WD_W-1:0] THRESH = WD_W'(TIMEOUT_CYC - 1);

    logic [WD_W-1:0] cnt_q;
    logic [WD_W-1:0] cnt_d;

    // Next count: clear wins, otherwise count up and stick at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != {WD_W{1'b1}})) begin
            cnt_d = cnt_q + WD_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            expired <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            expired <= (cnt_d >= THRESH);
        end
    end

endmodule

// File: rtl/nn_layer_sequencer.sv
// Central scheduler for the NN inference pipeline (ConV1 .. FC3).
// Starts each layer in turn, owns the shared-memory grant, and reports
// timeouts / spurious completions.
//   sys_clk, rst  : clock, asynchronous active-high reset
//   start_flag    : run request (rising edge only)
//   abort         : synchronous level abort, returns to idle
//   end_in        : per-layer one-cycle completion pulses
//   start_out     : per-layer one-cycle start pulses
//   grant         : one-hot memory ownership, zero when no owner
//   layer_sel     : binary index of granted layer, 4'hF when none
//   busy          : run in progress
//   end_flag      : run complete
//   error         : sticky error; err_layer / err_code describe it
//   cycle_count   : active cycles of the last or current run (saturating)
module nn_layer_sequencer
    import nn_seq_pkg::*;
#(
    parameter int unsigned NUM_LAYERS  = 8,
    parameter int unsigned TIMEOUT_CYC = 4000000,
    parameter int unsigned WD_W        = 23,
    parameter int unsigned CNT_W       = 32
) (
    input  logic                  sys_clk,
    input  logic                  rst,
    input  logic                  start_flag,
    input  logic                  abort,
    input  logic [NUM_LAYERS-1:0] end_in,
    output logic [NUM_LAYERS-1:0] start_out,
    output logic [NUM_LAYERS-1:0] grant,
    output logic [3:0]            layer_sel,
    output logic                  busy,
    output logic                  end_flag,
    output logic                  error,
    output logic [3:0]            err_layer,
    output logic [1:0]            err_code,
    output logic [CNT_W-1:0]      cycle_count
);

    localparam int unsigned        IDX_W    = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_LAYERS - 1);

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    start_q;
    logic                    start_edge;

    logic [NUM_LAYERS-1:0]   start_out_d;
    logic [NUM_LAYERS-1:0]   grant_d;
    logic [3:0]              layer_sel_d;
    logic                    busy_d;
    logic                    end_flag_d;
    logic                    error_d;
    logic [3:0]              err_layer_d;
    logic [1:0]              err_code_d;
    logic [CNT_W-1:0]        cycle_count_d;

    logic                    spur_hit;
    logic [3:0]              spur_idx;

    logic                    wd_clr;
    logic                    wd_en;
    logic                    wd_expired;

    assign start_edge = start_flag & ~start_q;
    assign wd_clr     = (state_q == S_LAUNCH);
    assign wd_en      = (state_q == S_WAIT);

    nn_seq_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .WD_W        (WD_W)
    ) u_wd (
        .clk     (sys_clk),
        .rst     (rst),
        .clr     (wd_clr),
        .en      (wd_en),
        .expired (wd_expired)
    );

    // Next state, bookkeeping and registered-output values.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        err_layer_d   = err_layer;
        err_code_d    = err_code;
        cycle_count_d = cycle_count;
        spur_hit      = 1'b0;
        spur_idx      = SEL_NONE;
        start_out_d   = '0;
        grant_d       = '0;
        layer_sel_d   = SEL_NONE;
        busy_d        = 1'b0;

        // Scan downward so the lowest foreign end pulse is the one reported.
        for (int j = NUM_LAYERS - 1; j >= 0; j--) begin
            if (end_in[j] && (IDX_W'(j) != idx_q)) begin
                spur_hit = 1'b1;
                spur_idx = 4'(j);
            end
        end

        if ((state_q inside {S_LAUNCH, S_WAIT, S_GAP}) &&
            (cycle_count != {CNT_W{1'b1}})) begin
            cycle_count_d = cycle_count + CNT_W'(1);
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_edge) begin
                    state_d       = S_LAUNCH;
                    idx_d         = '0;
                    cycle_count_d = '0;
                end
            end
            S_LAUNCH: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (end_in[idx_q]) begin
                    state_d = (idx_q == LAST_IDX) ? S_DONE : S_GAP;
                end else if (spur_hit) begin
                    state_d     = S_ERROR;
                    err_code_d  = ERR_SPURIOUS;
                    err_layer_d = spur_idx;
                end else if (wd_expired) begin
                    state_d     = S_ERROR;
                    err_code_d  = ERR_TIMEOUT;
                    err_layer_d = 4'(idx_q);
                end
            end
            S_GAP: begin
                idx_d   = idx_q + IDX_W'(1);
                state_d = S_LAUNCH;
            end
            S_ERROR: begin
                state_d = S_ERROR;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort overrides everything; the run-cycle count is kept for readback.
        if (abort) begin
            state_d       = S_IDLE;
            err_layer_d   = SEL_NONE;
            err_code_d    = ERR_NONE;
            cycle_count_d = cycle_count;
        end

        // Outputs follow the state being entered so they are registered with it.
        case (state_d)
            S_LAUNCH: begin
                start_out_d[idx_d] = 1'b1;
                grant_d[idx_d]     = 1'b1;
                layer_sel_d        = 4'(idx_d);
                busy_d             = 1'b1;
            end
            S_WAIT: begin
                grant_d[idx_d] = 1'b1;
                layer_sel_d    = 4'(idx_d);
                busy_d         = 1'b1;
            end
            S_GAP: begin
                busy_d = 1'b1;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase

        end_flag_d = (state_d == S_DONE);
        error_d    = (state_d == S_ERROR);
    end

    // State and output registers. start_q resets high so a start_flag that is
    // already asserted across reset must drop and rise again to start a run.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            start_q     <= 1'b1;
            start_out   <= '0;
            grant       <= '0;
            layer_sel   <= SEL_NONE;
            busy        <= 1'b0;
            end_flag    <= 1'b0;
            error       <= 1'b0;
            err_layer   <= SEL_NONE;
            err_code    <= ERR_NONE;
            cycle_count <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            start_q     <= start_flag;
            start_out   <= start_out_d;
            grant       <= grant_d;
            layer_sel   <= layer_sel_d;
            busy        <= busy_d;
            end_flag    <= end_flag_d;
            error       <= error_d;
            err_layer   <= err_layer_d;
            err_code    <= err_code_d;
            cycle_count <= cycle_count_d;
        end
    end

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Self-checking bench for nn_layer_sequencer: directed scenarios with random
// per-layer latencies, checked against a cycle-level behavioural model.
module tb_nn_layer_sequencer;

    localparam int unsigned N  = 8;
    localparam int unsigned T  = 50;
    localparam int unsigned CW = 32;

    logic          sys_clk = 1'b0;
    logic          rst;
    logic          start_flag;
    logic          abort;
    logic [N-1:0]  end_in;
    logic [N-1:0]  start_out;
    logic [N-1:0]  grant;
    logic [3:0]    layer_sel;
    logic          busy;
    logic          end_flag;
    logic          error;
    logic [3:0]    err_layer;
    logic [1:0]    err_code;
    logic [CW-1:0] cycle_count;

    nn_layer_sequencer #(
        .NUM_LAYERS  (N),
        .TIMEOUT_CYC (T),
        .WD_W        (8),
        .CNT_W       (CW)
    ) dut (
        .sys_clk     (sys_clk),
        .rst         (rst),
        .start_flag  (start_flag),
        .abort       (abort),
        .end_in      (end_in),
        .start_out   (start_out),
        .grant       (grant),
        .layer_sel   (layer_sel),
        .busy        (busy),
        .end_flag    (end_flag),
        .error       (error),
        .err_layer   (err_layer),
        .err_code    (err_code),
        .cycle_count (cycle_count)
    );

    always #5 sys_clk = ~sys_clk;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_cyc;        // model: active (launch/wait/gap) cycles of the current run
    int dly [N];        // per-layer responder latency, start pulse to end pulse

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge sys_clk);
    endtask

    function automatic logic [N-1:0] onehot(input int k);
        logic [N-1:0] v;
        v    = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    task automatic check_reset_vals(input string tag);
        check({tag, "_start_out"}, 32'(start_out), 32'h0);
        check({tag, "_grant"},     32'(grant),     32'h0);
        check({tag, "_layer_sel"}, 32'(layer_sel), 32'hF);
        check({tag, "_busy"},      32'(busy),      32'h0);
        check({tag, "_end_flag"},  32'(end_flag),  32'h0);
        check({tag, "_error"},     32'(error),     32'h0);
        check({tag, "_err_layer"}, 32'(err_layer), 32'hF);
        check({tag, "_err_code"},  32'(err_code),  32'h0);
        check({tag, "_cycles"},    32'(cycle_count), 32'h0);
    endtask

    // Fresh start edge from idle/done; layer 0 must be launched next cycle.
    task automatic start_run();
        start_flag = 1'b0;
        step();
        start_flag = 1'b1;
        step();
        exp_cyc = 0;
        check("launch0_start", 32'(start_out), 32'(onehot(0)));
        check("launch0_endflag", 32'(end_flag), 32'h0);
        check("launch0_cycles", 32'(cycle_count), 32'h0);
    endtask

    // Layer k was just launched: hold for d cycles then pulse its end.
    task automatic finish_layer(input int k, input int d);
        for (int i = 0; i < d; i++) begin
            step();
            check("grant_hold", 32'(grant), 32'(onehot(k)));
        end
        end_in = onehot(k);
        step();
        end_in = '0;
        exp_cyc += 1 + d;
    endtask

    // Run layers 0..k-1 to completion; returns with layer k just launched.
    task automatic run_to(input int k);
        for (int i = 0; i < k; i++) begin
            finish_layer(i, dly[i]);
            check("gap_grant", 32'(grant), 32'h0);
            check("gap_sel", 32'(layer_sel), 32'hF);
            check("gap_busy", 32'(busy), 32'h1);
            exp_cyc += 1;
            step();
            check("launch_start", 32'(start_out), 32'(onehot(i + 1)));
            check("launch_sel", 32'(layer_sel), 32'(i + 1));
        end
    endtask

    task automatic full_run();
        start_run();
        run_to(N - 1);
        finish_layer(N - 1, dly[N - 1]);
        check("done_endflag", 32'(end_flag), 32'h1);
        check("done_busy", 32'(busy), 32'h0);
        check("done_grant", 32'(grant), 32'h0);
        check("done_cycles", 32'(cycle_count), 32'(exp_cyc));
    endtask

    task automatic do_abort();
        abort = 1'b1;
        step();
        abort = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "bench stalled");
    end

    initial begin
        int k, j1, j2;
        rst        = 1'b1;
        start_flag = 1'b0;
        abort      = 1'b0;
        end_in     = '0;
        #12;
        check_reset_vals("rst");
        @(negedge sys_clk);
        rst = 1'b0;
        step();

        // Nominal run, every layer ends 10 cycles after its start.
        for (int i = 0; i < N; i++) dly[i] = 10;
        full_run();
        check("model_96ish", 32'(exp_cyc), 32'd95);
        // start_flag held high through DONE must not relaunch.
        for (int i = 0; i < 3; i++) step();
        check("level_start_out", 32'(start_out), 32'h0);
        check("level_endflag", 32'(end_flag), 32'h1);
        check("level_busy", 32'(busy), 32'h0);

        // Random-latency runs, each restarted from DONE by a low-high edge.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < N; i++) dly[i] = int'($urandom_range(1, 20));
            full_run();
        end

        // Timeout on layer 3.
        for (int i = 0; i < N; i++) dly[i] = int'($urandom_range(1, 20));
        start_run();
        run_to(3);
        for (int i = 0; i < T; i++) step();
        check("to_pre_error", 32'(error), 32'h0);
        check("to_pre_grant", 32'(grant), 32'(onehot(3)));
        step();
        exp_cyc += 1 + T;
        check("to_error", 32'(error), 32'h1);
        check("to_code", 32'(err_code), 32'h1);
        check("to_layer", 32'(err_layer), 32'h3);
        check("to_grant", 32'(grant), 32'h0);
        check("to_busy", 32'(busy), 32'h0);
        check("to_cycles", 32'(cycle_count), 32'(exp_cyc));
        start_flag = 1'b0;
        step();
        start_flag = 1'b1;
        step();
        step();
        check("err_ign_start", 32'(start_out), 32'h0);
        check("err_ign_error", 32'(error), 32'h1);
        do_abort();
        check("abort_error", 32'(error), 32'h0);
        check("abort_code", 32'(err_code), 32'h0);
        check("abort_layer", 32'(err_layer), 32'hF);
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_cycles", 32'(cycle_count), 32'(exp_cyc));

        // Spurious end from layer 5 (and 7) while layer 2 owns memory.
        start_run();
        run_to(2);
        step();
        step();
        end_in = onehot(5) | onehot(7);
        step();
        end_in = '0;
        check("sp_error", 32'(error), 32'h1);
        check("sp_code", 32'(err_code), 32'h2);
        check("sp_layer", 32'(err_layer), 32'h5);
        check("sp_grant", 32'(grant), 32'h0);
        do_abort();

        // Random spurious pair against a random owner.
        start_run();
        k = int'($urandom_range(0, N - 2));
        run_to(k);
        step();
        do j1 = int'($urandom_range(0, N - 1)); while (j1 == k);
        do j2 = int'($urandom_range(0, N - 1)); while (j2 == k);
        end_in = onehot(j1) | onehot(j2);
        step();
        end_in = '0;
        check("spr_code", 32'(err_code), 32'h2);
        check("spr_layer", 32'(err_layer), 32'((j1 < j2) ? j1 : j2));
        do_abort();

        // abort together with the owner's end: no next layer.
        start_run();
        step();
        step();
        end_in = onehot(0);
        abort  = 1'b1;
        step();
        end_in = '0;
        abort  = 1'b0;
        check("ab_end_busy", 32'(busy), 32'h0);
        check("ab_end_grant", 32'(grant), 32'h0);
        step();
        check("ab_end_start", 32'(start_out), 32'h0);

        // End arrives on the very cycle the watchdog expires: normal handoff.
        start_run();
        finish_layer(0, T);
        check("race_error", 32'(error), 32'h0);
        check("race_gap_busy", 32'(busy), 32'h1);
        check("race_gap_grant", 32'(grant), 32'h0);
        step();
        check("race_launch1", 32'(start_out), 32'(onehot(1)));
        do_abort();

        // Asynchronous reset in the wait of layer 4.
        for (int i = 0; i < N; i++) dly[i] = int'($urandom_range(1, 12));
        start_run();
        run_to(4);
        step();
        step();
        #2 rst = 1'b1;
        #1 check_reset_vals("arst");
        @(negedge sys_clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("arst_no_restart", 32'(start_out), 32'h0);
        check("arst_no_busy", 32'(busy), 32'h0);
        full_run();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
